// File: rtl/apb_pkg.sv
// Shared definitions for the APB request arbiter and its neighbours.
package apb_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Default bus widths used by the APB blocks.
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request at or above ptr,
// wrapping from the top requester back to requester 0.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Scan rotation offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    int               slot_i;
    logic [PTR_W-1:0] slot;
    valid  = 1'b0;
    idx    = '0;
    slot_i = 0;
    slot   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      slot_i = (int'(ptr) + off) % NREQ;
      slot   = PTR_W'(slot_i);
      if (req[slot]) begin
        valid = 1'b1;
        idx   = slot;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters, with a
// watchdog that aborts transfers whose ready never arrives.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     m_sel,
  output logic                     m_wr,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_ready,
  input  logic [DATA_W-1:0]        m_rdata
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] OWNER_TOP = PTR_W'(NREQ - 1);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] wd_cnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] ptr_after_owner;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Priority moves to the requester just above the one that was served.
  always_comb begin
    ptr_after_owner = (owner == OWNER_TOP) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM; every output is a register so nothing combinational reaches the ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      wd_cnt  <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      m_sel   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner   <= pick_idx;
            m_wr    <= req_wr[pick_idx];
            m_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            m_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            m_sel   <= 1'b1;
            busy    <= 1'b1;
            wd_cnt  <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (m_ready) begin
            if (!m_wr) begin
              rdata <= m_rdata;
            end
            err         <= 1'b0;
            m_sel       <= 1'b0;
            done[owner] <= 1'b1;
            state       <= RESP;
          end else if (wd_cnt == CNT_LAST) begin
            err         <= 1'b1;
            m_sel       <= 1'b0;
            done[owner] <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ptr    <= ptr_after_owner;
          wd_cnt <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scenario bench for apb_req_arbiter: expected completions are queued when a
// request is driven and popped when the arbiter pulses done.
module tb_apb_req_arbiter;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [NREQ-1:0]   done;
    logic              err;
    bit                chk_rd;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic                   m_sel;
  logic                   m_wr;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic                   m_ready;
  logic [DATA_W-1:0]      m_rdata;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  apb_req_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .m_sel     (m_sel),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic set_req_op(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    req_wr[i]                  = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req     = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_sel(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m_sel === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== '0)    begin n_fail++; $display("[TB] FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rdata !== '0)   begin n_fail++; $display("[TB] FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (m_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m_sel: got %b want 0", m_sel); end
    n_cmp++; if (m_wr !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_m_wr: got %b want 0", m_wr); end
    n_cmp++; if (m_addr !== '0)  begin n_fail++; $display("[TB] FAIL rst_m_addr: got %h want 0", m_addr); end
    n_cmp++; if (m_wdata !== '0) begin n_fail++; $display("[TB] FAIL rst_m_wdata: got %h want 0", m_wdata); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || m_sel !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_no_req: busy=%b m_sel=%b want 0/0", busy, m_sel);
    end
  endtask

  task automatic test_single_write();
    bit   ok;
    exp_t e;
    do_reset();
    set_req_op(2, 1'b1, 8'h3C, 32'hDEADBEEF);
    sb.push_back('{4'b0100, 1'b0, 1'b0, 32'h0});
    req = 4'b0100;
    wait_sel(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL wr_sel: m_sel never rose, want 1"); end
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      n_cmp++;
      if (m_sel !== 1'b1 || m_wr !== 1'b1 || m_addr !== 8'h3C || m_wdata !== 32'hDEADBEEF) begin
        n_fail++;
        $display("[TB] FAIL wr_stable: sel=%b wr=%b addr=%h wdata=%h want 1/1/3c/deadbeef",
                 m_sel, m_wr, m_addr, m_wdata);
      end
    end
    m_ready = 1'b1;
    wait_done(ok);
    m_ready = 1'b0;
    req     = '0;
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("[TB] FAIL wr_done_wait: done=%b, want a completion", done);
    end else begin
      e = sb.pop_front();
      if (done !== e.done || err !== e.err) begin
        n_fail++; $display("[TB] FAIL wr_done: done=%b err=%b want %b/%b", done, err, e.done, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   rise[$];
    int   exp_owner[5];
    logic prev;
    int   ndone;
    exp_t e;
    do_reset();
    exp_owner = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      set_req_op(i, i[0], 8'h10 + 8'(i), 32'hA000_0000 + i);
    end
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{4'b0001 << exp_owner[k], 1'b0, 1'b0, 32'h0});
    end
    m_ready = 1'b1;
    req     = 4'hF;
    prev    = 1'b0;
    ndone   = 0;
    for (int c = 0; c < 60 && ndone < 5; c++) begin
      @(negedge clk);
      if (m_sel === 1'b1 && prev !== 1'b1) begin
        if (rise.size() < 5) begin
          n_cmp++;
          if (m_addr !== 8'h10 + 8'(exp_owner[rise.size()])) begin
            n_fail++; $display("[TB] FAIL rr_grant_addr: got %h want %h", m_addr,
                               8'h10 + 8'(exp_owner[rise.size()]));
          end
        end
        rise.push_back(c);
      end
      prev = m_sel;
      if (done !== '0) begin
        ndone++;
        if (ndone == 5) req = '0;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL rr_extra_done: got %b want none", done);
        end else begin
          e = sb.pop_front();
          if (done !== e.done || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rr_order: done=%b err=%b want %b/0", done, err, e.done);
          end
        end
      end
    end
    m_ready = 1'b0;
    req     = '0;
    n_cmp++;
    if (ndone != 5 || rise.size() != 5) begin
      n_fail++; $display("[TB] FAIL rr_count: dones=%0d grants=%0d want 5/5", ndone, rise.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        n_cmp++;
        if (rise[k] - rise[k-1] != 3) begin
          n_fail++; $display("[TB] FAIL rr_spacing: got %0d want 3", rise[k] - rise[k-1]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit   raised;
    int   nd;
    exp_t e;
    do_reset();
    set_req_op(0, 1'b1, 8'h20, 32'h0000_0020);
    set_req_op(3, 1'b1, 8'h23, 32'h0000_0023);
    sb.push_back('{4'b0001, 1'b0, 1'b0, 32'h0});
    sb.push_back('{4'b1000, 1'b0, 1'b0, 32'h0});
    sb.push_back('{4'b0001, 1'b0, 1'b0, 32'h0});
    m_ready = 1'b1;
    req     = 4'b0001;
    raised  = 1'b0;
    nd      = 0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      @(negedge clk);
      if (m_sel === 1'b1 && !raised) begin
        req[3] = 1'b1;
        raised = 1'b1;
      end
      if (done !== '0) begin
        nd++;
        if (done[3] === 1'b1) req[3] = 1'b0;
        if (nd == 3) req = '0;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL fair_extra_done: got %b want none", done);
        end else begin
          e = sb.pop_front();
          if (done !== e.done) begin
            n_fail++; $display("[TB] FAIL fair_order: got %b want %b", done, e.done);
          end
        end
      end
    end
    m_ready = 1'b0;
    req     = '0;
    n_cmp++;
    if (nd != 3) begin n_fail++; $display("[TB] FAIL fair_count: got %0d want 3", nd); end
    @(negedge clk);
  endtask

  task automatic test_read();
    bit   ok;
    exp_t e;
    do_reset();
    set_req_op(1, 1'b0, 8'h44, 32'h0);
    m_rdata = '0;
    sb.push_back('{4'b0010, 1'b0, 1'b1, 32'h12345678});
    req = 4'b0010;
    wait_sel(ok);
    n_cmp++;
    if (!ok || m_wr !== 1'b0 || m_addr !== 8'h44) begin
      n_fail++; $display("[TB] FAIL rd_sel: sel=%b wr=%b addr=%h want 1/0/44", m_sel, m_wr, m_addr);
    end
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h12345678;
    wait_done(ok);
    m_ready = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    req     = '0;
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("[TB] FAIL rd_done_wait: done=%b, want a completion", done);
    end else begin
      e = sb.pop_front();
      if (done !== e.done || err !== e.err || (e.chk_rd && rdata !== e.rdata)) begin
        n_fail++; $display("[TB] FAIL rd_done: done=%b err=%b rdata=%h want %b/%b/%h",
                           done, err, rdata, e.done, e.err, e.rdata);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdata !== 32'h12345678) begin
      n_fail++; $display("[TB] FAIL rd_hold: got %h want 12345678", rdata);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    int   selcnt;
    exp_t e;
    do_reset();
    set_req_op(2, 1'b1, 8'h32, 32'h0000_0032);
    set_req_op(3, 1'b1, 8'h33, 32'h0000_0033);
    m_rdata = 32'h5555_AAAA;
    sb.push_back('{4'b0100, 1'b1, 1'b1, 32'h0});
    sb.push_back('{4'b1000, 1'b0, 1'b0, 32'h0});
    req    = 4'b1100;
    selcnt = 0;
    ok     = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (m_sel === 1'b1) selcnt++;
      if (done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    req[2] = 1'b0;
    n_cmp++;
    if (selcnt != TIMEOUT) begin
      n_fail++; $display("[TB] FAIL to_sel_len: got %0d want %0d", selcnt, TIMEOUT);
    end
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("[TB] FAIL to_done_wait: done=%b, want a completion", done);
    end else begin
      e = sb.pop_front();
      if (done !== e.done || err !== e.err || rdata !== e.rdata) begin
        n_fail++; $display("[TB] FAIL to_done: done=%b err=%b rdata=%h want %b/%b/%h",
                           done, err, rdata, e.done, e.err, e.rdata);
      end
    end
    wait_sel(ok);
    n_cmp++;
    if (!ok || m_addr !== 8'h33) begin
      n_fail++; $display("[TB] FAIL to_next_grant: sel=%b addr=%h want 1/33", m_sel, m_addr);
    end
    m_ready = 1'b1;
    wait_done(ok);
    m_ready = 1'b0;
    req     = '0;
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_fail++; $display("[TB] FAIL to_next_wait: done=%b, want a completion", done);
    end else begin
      e = sb.pop_front();
      if (done !== e.done || err !== e.err) begin
        n_fail++; $display("[TB] FAIL to_next_done: done=%b err=%b want %b/%b", done, err, e.done, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    do_reset();
    set_req_op(0, 1'b1, 8'h50, 32'h0000_0050);
    set_req_op(1, 1'b1, 8'h51, 32'h0000_0051);
    req = 4'b0010;
    wait_sel(ok);
    n_cmp++;
    if (!ok || m_addr !== 8'h51) begin
      n_fail++; $display("[TB] FAIL rm_first_grant: sel=%b addr=%h want 1/51", m_sel, m_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if ({done, err, rdata, busy, m_sel, m_wr, m_addr, m_wdata} !== '0) begin
      n_fail++; $display("[TB] FAIL rm_cleared: done=%b err=%b busy=%b sel=%b addr=%h want all 0",
                         done, err, busy, m_sel, m_addr);
    end
    rst = 1'b1;
    sb.push_back('{4'b0001, 1'b0, 1'b0, 32'h0});
    sb.push_back('{4'b0010, 1'b0, 1'b0, 32'h0});
    wait_sel(ok);
    n_cmp++;
    if (!ok || m_addr !== 8'h50) begin
      n_fail++; $display("[TB] FAIL rm_after_grant: sel=%b addr=%h want 1/50", m_sel, m_addr);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_done(ok);
      if (k == 0) req[0] = 1'b0;
      else        req    = '0;
      n_cmp++;
      if (!ok || sb.size() == 0) begin
        n_fail++; $display("[TB] FAIL rm_done_wait: done=%b, want a completion", done);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || err !== e.err) begin
          n_fail++; $display("[TB] FAIL rm_done: done=%b err=%b want %b/%b", done, err, e.done, e.err);
        end
      end
    end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_fairness();
    test_read();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("[TB] FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single `apb_master` among four independent requesters. Each requester holds a request with its write flag, address and write data. The arbiter selects one requester, drives the master's `sel/wr_in/addr_in/data_in` inputs stably until `ready`, then returns a one-cycle completion pulse with read data and status. It sits directly in front of `apb_master` in the APB top level. A watchdog aborts transfers whose `ready` never arrives.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: maximum cycles in BUSY without `m_ready` before abort (≥2).

- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `req`  in  NREQ: per-requester request level.
- `req_wr`  in  NREQ: per-requester write(1)/read(0).
- `req_addr`  in  NREQ*ADDR_W: packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NREQ*DATA_W: packed write data, same packing.
- `done`  out  NREQ: one-hot, one-cycle completion pulse to the owner.
- `err`  out  1: valid with `done`; 1 means timeout abort.
- `rdata`  out  DATA_W: read data, valid with `done` for reads; holds its value otherwise.
- `busy`  out  1: high in BUSY and RESP.
- `m_sel`  out  1: to master `sel`.
- `m_wr`  out  1: to master `wr_in`.
- `m_addr`  out  ADDR_W: to master `addr_in`.
- `m_wdata`  out  DATA_W: to master `data_in`.
- `m_ready`  in  1: transfer-complete from slave.
- `m_rdata`  in  DATA_W: read data from slave.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, any `req` bit set:
  - Select the first set bit searching upward from `ptr`, wrapping NREQ-1→0.
  - Latch the owner index and its wr/addr/wdata into `m_*` registers.
  - Go to BUSY. `ptr` is not updated at this point.
- IDLE, no requests: stay in IDLE.
- BUSY:
  - `m_sel`=1; `m_wr/m_addr/m_wdata` stay constant.
  - Watchdog counter increments each cycle.
  - On `m_ready`=1: capture `m_rdata` into `rdata` if read; `err`←0; go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: `err`←1; go to RESP. `rdata` is unchanged.
- RESP:
  - `m_sel`=0; `done[owner]`=1 for exactly this cycle.
  - `ptr`←(owner+1) mod NREQ; counter cleared; go to IDLE.
- Requester contract: hold `req` and its operands until its `done`.
  - Deasserting `req` during BUSY does not cancel the transfer; `done` still pulses.
  - `req` still high in the IDLE cycle after its `done` starts a new transfer, subject to arbitration.
- `m_ready` outside BUSY is ignored.
- `m_ready` in the same cycle as the timeout edge: `m_ready` wins, so `err`=0.

## Timing
- Reset values: state=IDLE, `ptr`=0, counter=0. All outputs 0: `done`, `err`, `rdata`, `busy`, `m_sel`, `m_wr`, `m_addr`, `m_wdata`.
- Reset mid-transfer: immediate return to IDLE with all reset values. No `done` is issued for the aborted transfer.
- Latency, with `req` rising in IDLE at cycle 0:
  - `m_sel`=1 from cycle 1.
  - `m_ready` sampled at cycle k (k≥1) gives `done` at cycle k+1.
  - Earliest next `m_sel` is cycle k+3: RESP, then one IDLE arbitration cycle.
- Back-to-back throughput: one transfer per (ready latency + 2) cycles.
- Timeout: with `m_ready` never asserted, `m_sel` is high for exactly TIMEOUT cycles. `done`/`err` follow in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `apb_pkg`:
  - State enum `arb_state_t` {IDLE, BUSY, RESP}.
  - Default width constants `APB_ADDR_W`=8 and `APB_DATA_W`=32.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs: `req` vector and `ptr`. Outputs: index and `valid`.
- Top-level integration: the arbiter's `m_*` ports connect to `apb_master` in place of the direct external inputs.

## Test plan
- Single write: `req[2]`=1, wr=1, addr=0x3C, wdata=0xDEADBEEF, `m_ready` 2 cycles after `m_sel`.
  - Required: `m_addr`=0x3C and `m_wdata`=0xDEADBEEF stable while `m_sel`=1.
  - Required: `done`=4'b0100 one cycle after ready; `err`=0.
- All four requesting continuously from reset, ready=1 each BUSY cycle.
  - Required: grant order 0,1,2,3,0.
  - Required: `m_sel` pulses exactly 3 cycles apart.
- Fairness: `req[0]` held permanently, `req[3]` raised during requester 0's transfer.
  - Required: requester 3 is served next, before requester 0 again.
- Read: `req[1]`=1, wr=0, `m_rdata`=0x12345678 with `m_ready`.
  - Required: `rdata`=0x12345678 with `done[1]`; `rdata` holds afterward.
- Timeout: `m_ready` tied 0, TIMEOUT=16.
  - Required: `m_sel` high 16 cycles, then `done` with `err`=1; arbiter then serves the next requester.
- Reset mid-BUSY: `rst`=0 for one cycle.
  - Required: next cycle all outputs 0, no `done`.
  - Required: after release, a pending `req[0]` is served first.
